mult_div: RTL and testbench

- Iterative 32-bit signed integer multiplier/divider for the processor execute stage.
- A one-cycle start pulse on ctrl_MULT or ctrl_DIV launches a multi-cycle operation.
- Completion is flagged by a one-cycle data_resultRDY pulse, with the 32-bit result and an exception flag.
- Single shared datapath: radix-2 Booth multiply, non-restoring divide.

---
 rtl/mult_div_pkg.sv | 23 ++
 rtl/mult_div_counter.sv | 37 +++
 rtl/mult_div.sv | 211 +++++++++++++++++++++
 tb/tb_mult_div.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared constants and types for the iterative multiplier/divider.
//   WIDTH   : operand/result width
//   ITER    : number of datapath iterations per operation
//   INT_MIN : most negative signed WIDTH-bit value
//   state_t : FSM state encoding used by mult_div
// -----------------------------------------------------------------------------
package mult_div_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_counter.sv
// -----------------------------------------------------------------------------
// mult_div_counter
// Iteration counter for the multiply/divide datapath.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   clear   : synchronous clear, asserted on an operation start
//   enable  : advance by one iteration
//   done    : high once ITER iterations have been counted
// -----------------------------------------------------------------------------
module mult_div_counter
    import mult_div_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [CNT_W-1:0] count;

    assign done = (count == CNT_W'(ITER));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div
// Iterative signed 32-bit multiplier/divider sharing one shift datapath:
// radix-2 Booth multiply and non-restoring divide on magnitudes, one
// iteration per clock. A start is the rising edge of the registered ctrl
// input; operands are captured on that edge. data_resultRDY pulses for one
// cycle 33 edges after the start edge; result/exception hold until the next
// completion or reset.
//
// Optional build macro: MULT_DIV_REMAINDER_EN adds data_remainder (signed
// remainder of a divide, sign of the dividend; 0 after multiply/div-by-zero).
//
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   data_operandA / B       : multiplicand/dividend, multiplier/divisor
//   ctrl_MULT / ctrl_DIV    : start pulses (multiply wins if both rise)
//   data_result             : product low word / quotient
//   data_exception          : multiply overflow, div-by-zero, INT_MIN/-1
//   data_resultRDY          : one-cycle completion pulse
//   data_remainder          : (MULT_DIV_REMAINDER_EN only) signed remainder
// -----------------------------------------------------------------------------
module mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef MULT_DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    import mult_div_pkg::*;

    state_t state;

    // Registered ctrl inputs for rising-edge start detection.
    logic mult_q, div_q;
    logic start_mult, start_div, start;

    // Shared datapath: acc is one bit wider than WIDTH so the Booth add of
    // INT_MIN and the non-restoring partial remainder never overflow.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qr;
    logic             q_1;
    logic [WIDTH:0]   m;

    logic neg_quot, div_zero, div_ovf;

    logic cnt_done, cnt_en;

    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift, div_next;
    logic [WIDTH-1:0] mult_res, div_res;
    logic             mult_exc, div_exc;

    assign start_mult = ctrl_MULT & ~mult_q;
    assign start_div  = ctrl_DIV  & ~div_q;
    assign start      = start_mult | start_div;

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign cnt_en = ((state == MULT) || (state == DIV)) && !cnt_done && !start;

    mult_div_counter #(.CNT_W(CNT_W)) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start),
        .enable  (cnt_en),
        .done    (cnt_done)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        booth_sum = acc;
        case ({qr[0], q_1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase

        // Non-restoring step: shift in the next dividend bit, then subtract
        // the divisor if the partial remainder is non-negative, else add it.
        div_shift = {acc[WIDTH-1:0], qr[WIDTH-1]};
        div_next  = acc[WIDTH] ? (div_shift + m) : (div_shift - m);

        // Multiply completion: the product is {acc[WIDTH-1:0], qr}.
        mult_res = qr;
        mult_exc = (acc[WIDTH-1:0] != {WIDTH{qr[WIDTH-1]}});

        // Divide completion: INT_MIN / -1 yields 0x80000000 naturally from
        // the magnitude quotient; only the exception flag is forced.
        div_res = '0;
        div_exc = 1'b1;
        if (!div_zero) begin
            div_res = neg_quot ? -qr : qr;
            div_exc = div_ovf;
        end
    end

`ifdef MULT_DIV_REMAINDER_EN
    logic             neg_rem;
    logic [WIDTH-1:0] rem_mag, div_rem;

    always_comb begin
        // A negative final partial remainder needs one restoring add.
        rem_mag = acc[WIDTH] ? (acc[WIDTH-1:0] + m[WIDTH-1:0]) : acc[WIDTH-1:0];
        div_rem = '0;
        if (!div_zero) begin
            div_rem = neg_rem ? -rem_mag : rem_mag;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            neg_rem        <= 1'b0;
            data_remainder <= '0;
        end else if (start_div && !start_mult) begin
            neg_rem <= data_operandA[WIDTH-1];
        end else if (!start && cnt_done) begin
            if (state == MULT) data_remainder <= '0;
            if (state == DIV)  data_remainder <= div_rem;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: all datapath registers are reset, not just the FSM, so a
        // reset mid-operation leaves no stale operand or partial result.
        if (!reset_n) begin
            state          <= IDLE;
            mult_q         <= 1'b0;
            div_q          <= 1'b0;
            acc            <= '0;
            qr             <= '0;
            q_1            <= 1'b0;
            m              <= '0;
            neg_quot       <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            mult_q         <= ctrl_MULT;
            div_q          <= ctrl_DIV;
            data_resultRDY <= 1'b0;

            if (start_mult) begin
                state <= MULT;
                acc   <= '0;
                qr    <= data_operandB;
                q_1   <= 1'b0;
                m     <= {data_operandA[WIDTH-1], data_operandA};
            end else if (start_div) begin
                state    <= DIV;
                acc      <= '0;
                qr       <= a_mag;
                q_1      <= 1'b0;
                m        <= {1'b0, b_mag};
                neg_quot <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
            end else begin
                case (state)
                    MULT: begin
                        if (!cnt_done) begin
                            // Arithmetic right shift of {acc, qr, q_1}.
                            acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                            qr  <= {booth_sum[0], qr[WIDTH-1:1]};
                            q_1 <= qr[0];
                        end else begin
                            data_result    <= mult_res;
                            data_exception <= mult_exc;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    DIV: begin
                        if (!cnt_done) begin
                            acc <= div_next;
                            qr  <= {qr[WIDTH-2:0], ~div_next[WIDTH]};
                        end else begin
                            data_result    <= div_res;
                            data_exception <= div_exc;
                            data_resultRDY <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// -----------------------------------------------------------------------------
// tb_mult_div
// Self-checking bench for mult_div. A behavioural model computes expected
// outputs with plain integer arithmetic and a completion deadline; a compare
// process checks every cycle. Directed cases pin literal values, then a
// randomized phase exercises aborts, held ctrl and special operands.
// Define MULT_DIV_REMAINDER_EN for both RTL and bench to check data_remainder.
// -----------------------------------------------------------------------------
module tb_mult_div;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
`ifdef MULT_DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mult_div dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef MULT_DIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic void model_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic exc, output logic [31:0] rem);
        longint p;
        int sa, sb;
        sa = a;
        sb = b;
        rem = '0;
        if (is_mult) begin
            p   = longint'(sa) * longint'(sb);
            res = p[31:0];
            exc = (p != longint'(int'(p[31:0])));
        end else if (b == 0) begin
            res = '0;
            exc = 1'b1;
        end else if (a == INT_MIN && sb == -1) begin
            res = INT_MIN;
            exc = 1'b1;
        end else begin
            res = sa / sb;
            rem = sa % sb;
            exc = 1'b0;
        end
    endfunction

    logic        exp_rdy = 1'b0;
    logic [31:0] exp_res = '0;
    logic        exp_exc = 1'b0;
    logic [31:0] exp_rem = '0;

    initial begin
        bit prev_m, prev_d, pend, sm, sd;
        int cyc, due;
        logic [31:0] p_res, p_rem;
        logic        p_exc;
        prev_m = 0; prev_d = 0; pend = 0; cyc = 0; due = 0;
        p_res = '0; p_rem = '0; p_exc = 0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                prev_m = 0; prev_d = 0; pend = 0;
                exp_rdy = 0; exp_res = '0; exp_exc = 0; exp_rem = '0;
            end else begin
                cyc++;
                sm = ctrl_MULT && !prev_m;
                sd = ctrl_DIV && !prev_d;
                exp_rdy = 0;
                if (sm || sd) begin
                    // A new start abandons any pending operation.
                    pend = 1;
                    due  = cyc + 33;
                    model_op(sm, data_operandA, data_operandB, p_res, p_exc, p_rem);
                end else if (pend && cyc == due) begin
                    pend = 0;
                    exp_rdy = 1;
                    exp_res = p_res;
                    exp_exc = p_exc;
                    exp_rem = p_rem;
                end
                prev_m = ctrl_MULT;
                prev_d = ctrl_DIV;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("rdy", 64'(data_resultRDY), 64'(exp_rdy));
                check("result", 64'(data_result), 64'(exp_res));
                check("exception", 64'(data_exception), 64'(exp_exc));
`ifdef MULT_DIV_REMAINDER_EN
                check("remainder", 64'(data_remainder), 64'(exp_rem));
`endif
            end
        end
    end

    // Launch one operation and wait (bounded) for its completion pulse.
    // Start is sampled at the posedge after the driving negedge; RDY is
    // raised 33 edges later and first seen on the 34th negedge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit mul, input bit dv);
        int lat;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = mul;
        ctrl_DIV = dv;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) begin
                ctrl_MULT = 1'b0;
                ctrl_DIV = 1'b0;
                data_operandA = 32'h1234_5678;
                data_operandB = 32'h0000_0003;
            end
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(34));
        @(negedge clock);
        check("rdy_one_cycle", 64'(data_resultRDY), 64'(0));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return INT_MIN;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit saw_rdy;
        int gap, hold, kind;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_result", 64'(data_result), 64'(0));
        check("reset_exc", 64'(data_exception), 64'(0));
        check("reset_rdy", 64'(data_resultRDY), 64'(0));
        reset_n = 1'b1;

        // Directed cases with literal expectations
        do_op(32'd16777215, -32'sd13421772, 1, 0);
        check("big_mult_res", 64'(data_result), 64'h34CC_CCCC);
        check("big_mult_exc", 64'(data_exception), 64'(1));

        do_op(32'd6, -32'sd7, 1, 0);
        check("mult_neg_res", 64'(data_result), 64'hFFFF_FFD6);
        check("mult_neg_exc", 64'(data_exception), 64'(0));

        do_op(-32'sd8, 32'd3, 0, 1);
        check("div_res", 64'(data_result), 64'hFFFF_FFFE);
        check("div_exc", 64'(data_exception), 64'(0));
`ifdef MULT_DIV_REMAINDER_EN
        check("div_rem", 64'(data_remainder), 64'hFFFF_FFFE);
`endif

        do_op(32'd5, 32'd0, 0, 1);
        check("div0_res", 64'(data_result), 64'(0));
        check("div0_exc", 64'(data_exception), 64'(1));

        do_op(INT_MIN, 32'hFFFF_FFFF, 0, 1);
        check("divovf_res", 64'(data_result), 64'h8000_0000);
        check("divovf_exc", 64'(data_exception), 64'(1));

        do_op(32'd7, 32'd9, 1, 1);
        check("both_mult_wins", 64'(data_result), 64'(63));

        // Abort: multiply, then a divide start 10 cycles later
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT = 1'b1;
        saw_rdy = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            saw_rdy |= data_resultRDY;
        end
        check("no_rdy_before_abort", 64'(saw_rdy), 64'(0));
        do_op(32'd100, 32'd7, 0, 1);
        check("abort_div_res", 64'(data_result), 64'(14));

        // Asynchronous reset in the middle of a multiply
        @(negedge clock);
        data_operandA = 32'd123456;
        data_operandB = 32'd789;
        ctrl_MULT = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_result", 64'(data_result), 64'(0));
        check("async_rst_exc", 64'(data_exception), 64'(0));
        check("async_rst_rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        saw_rdy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            saw_rdy |= data_resultRDY;
        end
        check("no_rdy_after_reset", 64'(saw_rdy), 64'(0));
        do_op(32'd2, 32'd2, 1, 0);
        check("post_reset_mult", 64'(data_result), 64'(4));

        // Randomized phase: the compare process checks against the model
        repeat (80) begin
            @(negedge clock);
            data_operandA = rand_operand();
            data_operandB = rand_operand();
            kind = $urandom_range(0, 8);
            ctrl_MULT = (kind <= 3) || (kind == 8);
            ctrl_DIV = (kind >= 4);
            hold = $urandom_range(1, 3);
            repeat (hold) @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV = 1'b0;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : $urandom_range(33, 40);
            repeat (gap) begin
                @(negedge clock);
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
        end
        repeat (45) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
